// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pin-bank arbiter.
package uio_arb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REQ0   = 0;
  localparam int unsigned REQ1   = 1;

  localparam logic [DATA_W-1:0] OE_NONE = 8'h00;
  localparam logic [DATA_W-1:0] OE_ALL  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Requester and pin-side signals of the uio arbiter; slave = arbiter, master = core/pins.
interface uio_bus_arbiter_if;
  import uio_arb_pkg::*;

  logic [1:0]        req;
  logic [1:0]        wr;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [DATA_W-1:0] uio_in;
  logic [DATA_W-1:0] uio_out;
  logic [DATA_W-1:0] uio_oe;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output req, wr, wdata0, wdata1, uio_in,
    input  gnt, uio_out, uio_oe, rdata, rvalid
  );

  modport slave (
    input  req, wr, wdata0, wdata1, uio_in,
    output gnt, uio_out, uio_oe, rdata, rvalid
  );

endinterface

// File: rtl/uio_rr_pick.sv
// Combinational 2-way picker: round-robin on ties, or requester 0 when fixed is set.
module uio_rr_pick
  import uio_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [0:0] last,
  input  logic       fixed,
  output logic       win_valid,
  output logic       win_idx
);

  always_comb begin
    win_valid = |req;
    win_idx   = 1'(REQ0);
    if (req == 2'b11) begin
      win_idx = fixed ? 1'(REQ0) : ~last[0];
    end else if (req[REQ1]) begin
      win_idx = 1'(REQ1);
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Arbitrates the uio pin bank between two requesters with hold limit and turnaround.
// Build option: define UIO_ARB_FIXED_PRIORITY_EN for fixed priority to requester 0 on ties.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  uio_bus_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] GRANT = ST_GRANT;
  localparam logic [1:0] TURN  = ST_TURN;

  localparam logic [2:0] TURN_LAST = 3'(TURNAROUND - 1);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

`ifdef UIO_ARB_FIXED_PRIORITY_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  logic [1:0]        state, state_n;
  logic [1:0]        gnt_q, gnt_n;
  logic [DATA_W-1:0] oe_q, oe_n;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              owner_wr, owner_wr_n;
  logic              last, last_n;
  logic              forced, forced_n;
  logic [7:0]        hold_cnt, hold_n;
  logic [2:0]        turn_cnt, turn_n;
  logic              grant_now;
  logic              rd_en;

  logic       owner;
  logic       own_req;
  logic       other_req;
  logic [1:0] pick_req;
  logic       win_valid;
  logic       win_idx;

  assign owner     = gnt_q[1];
  assign own_req   = bus.req[owner];
  assign other_req = bus.req[~owner];

  // After a forced release, the evicted owner sits out the next pick if the other still waits.
  always_comb begin
    pick_req = bus.req;
    if (forced && bus.req[~last]) begin
      pick_req = last ? 2'b01 : 2'b10;
    end
  end

  uio_rr_pick u_pick (
    .req       (pick_req),
    .last      (last),
    .fixed     (FIXED_PRIO),
    .win_valid (win_valid),
    .win_idx   (win_idx)
  );

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    gnt_n      = gnt_q;
    oe_n       = oe_q;
    owner_wr_n = owner_wr;
    last_n     = last;
    forced_n   = forced;
    hold_n     = hold_cnt;
    turn_n     = turn_cnt;
    grant_now  = 1'b0;

    if (!ena) begin
      state_n  = IDLE;
      gnt_n    = 2'b00;
      oe_n     = OE_NONE;
      hold_n   = 8'd0;
      turn_n   = 3'd0;
      forced_n = 1'b0;
    end else begin
      case (state)
        IDLE: grant_now = win_valid;
        GRANT: begin
          if (!own_req || (hold_cnt == HOLD_LAST && other_req)) begin
            state_n  = TURN;
            gnt_n    = 2'b00;
            oe_n     = OE_NONE;
            turn_n   = 3'd0;
            forced_n = own_req;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_n = hold_cnt + 8'd1;
          end
        end
        TURN: begin
          if (turn_cnt == TURN_LAST) begin
            state_n   = IDLE;
            grant_now = win_valid;
          end else begin
            turn_n = turn_cnt + 3'd1;
          end
        end
        default: begin
          state_n = IDLE;
          gnt_n   = 2'b00;
          oe_n    = OE_NONE;
        end
      endcase
    end

    if (grant_now) begin
      state_n    = GRANT;
      gnt_n      = win_idx ? 2'b10 : 2'b01;
      owner_wr_n = bus.wr[win_idx];
      oe_n       = bus.wr[win_idx] ? OE_ALL : OE_NONE;
      last_n     = win_idx;
      hold_n     = 8'd0;
      forced_n   = 1'b0;
    end
  end

  // Read sampling only while the reading owner keeps the bus into the next cycle
  assign rd_en = (state == GRANT) && !owner_wr && (state_n == GRANT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= 2'b00;
      oe_q     <= OE_NONE;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      owner_wr <= 1'b0;
      last     <= 1'b1;
      forced   <= 1'b0;
      hold_cnt <= 8'd0;
      turn_cnt <= 3'd0;
    end else begin
      state    <= state_n;
      gnt_q    <= gnt_n;
      oe_q     <= oe_n;
      rvalid_q <= rd_en;
      owner_wr <= owner_wr_n;
      last     <= last_n;
      forced   <= forced_n;
      hold_cnt <= hold_n;
      turn_cnt <= turn_n;
      if (rd_en) begin
        rdata_q <= bus.uio_in;
      end
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.uio_oe  = oe_q;
  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.uio_out = (owner_wr && (gnt_q != 2'b00)) ?
                       (gnt_q[1] ? bus.wdata1 : bus.wdata0) : OE_NONE;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed self-checking bench for uio_bus_arbiter (TURNAROUND=1 and TURNAROUND=3 instances).
module tb_uio_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uio_bus_arbiter_if bus ();
  uio_bus_arbiter_if bus3 ();

  uio_bus_arbiter #(.TURNAROUND(1), .MAX_HOLD(16)) dut (
    .clk (clk), .rst (rst), .ena (ena), .bus (bus)
  );

  uio_bus_arbiter #(.TURNAROUND(3), .MAX_HOLD(16)) dut3 (
    .clk (clk), .rst (rst), .ena (ena), .bus (bus3)
  );

  typedef struct {
    logic       ena;
    logic [1:0] req;
    logic [1:0] wr;
    logic [7:0] wd0;
    logic [7:0] wd1;
    logic [7:0] uin;
    logic [1:0] gnt;
    logic [7:0] oe;
    logic [7:0] out;
    logic [7:0] rdata;
    logic       rvalid;
  } vec_t;

  vec_t tv[18];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic inv(input string nm, input logic [1:0] g, input logic [7:0] oe);
    logic ok;
    ok = $onehot0(g) && (oe == 8'h00 || oe == 8'hFF) && !(g == 2'b00 && oe != 8'h00);
    chk({nm, " invariant"}, 8'(ok), 8'd1);
  endtask

  task automatic chk_bus(input string nm, input logic [1:0] g, input logic [7:0] oe,
                         input logic [7:0] o);
    chk({nm, " gnt"}, 8'(bus.gnt), 8'(g));
    chk({nm, " uio_oe"}, bus.uio_oe, oe);
    chk({nm, " uio_out"}, bus.uio_out, o);
    inv(nm, bus.gnt, bus.uio_oe);
  endtask

  initial begin
    logic [1:0] eg;
    logic [7:0] eo;

    //        ena req    wr     wd0    wd1    uin     gnt    oe     out    rdata  rv
    tv[0]  = '{1'b1, 2'b00, 2'b00, 8'hA5, 8'h5A, 8'h00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0};
    tv[1]  = '{1'b1, 2'b01, 2'b01, 8'hA5, 8'h5A, 8'h00, 2'b01, 8'hFF, 8'hA5, 8'h00, 1'b0};
    tv[2]  = '{1'b1, 2'b01, 2'b01, 8'hA5, 8'h5A, 8'h00, 2'b01, 8'hFF, 8'hA5, 8'h00, 1'b0};
    tv[3]  = '{1'b1, 2'b01, 2'b01, 8'hC3, 8'h5A, 8'h00, 2'b01, 8'hFF, 8'hC3, 8'h00, 1'b0};
    tv[4]  = '{1'b1, 2'b00, 2'b01, 8'hC3, 8'h5A, 8'h00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0};
    tv[5]  = '{1'b1, 2'b00, 2'b00, 8'hC3, 8'h5A, 8'h00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0};
    tv[6]  = '{1'b1, 2'b10, 2'b00, 8'hC3, 8'h5A, 8'h3C, 2'b10, 8'h00, 8'h00, 8'h00, 1'b0};
    tv[7]  = '{1'b1, 2'b10, 2'b00, 8'hC3, 8'h5A, 8'h3C, 2'b10, 8'h00, 8'h00, 8'h3C, 1'b1};
    tv[8]  = '{1'b1, 2'b10, 2'b11, 8'hC3, 8'h5A, 8'h77, 2'b10, 8'h00, 8'h00, 8'h77, 1'b1};
    tv[9]  = '{1'b1, 2'b00, 2'b11, 8'hC3, 8'h5A, 8'h11, 2'b00, 8'h00, 8'h00, 8'h77, 1'b0};
    tv[10] = '{1'b1, 2'b11, 2'b01, 8'hA5, 8'h5A, 8'h11, 2'b01, 8'hFF, 8'hA5, 8'h77, 1'b0};
    tv[11] = '{1'b1, 2'b10, 2'b01, 8'hA5, 8'h5A, 8'h11, 2'b00, 8'h00, 8'h00, 8'h77, 1'b0};
    tv[12] = '{1'b1, 2'b10, 2'b01, 8'hA5, 8'h5A, 8'h11, 2'b10, 8'h00, 8'h00, 8'h77, 1'b0};
    tv[13] = '{1'b0, 2'b10, 2'b01, 8'hA5, 8'h5A, 8'h11, 2'b00, 8'h00, 8'h00, 8'h77, 1'b0};
    tv[14] = '{1'b1, 2'b11, 2'b10, 8'hA5, 8'h5A, 8'h11, 2'b01, 8'h00, 8'h00, 8'h77, 1'b0};
    tv[15] = '{1'b1, 2'b11, 2'b10, 8'hA5, 8'h5A, 8'hE7, 2'b01, 8'h00, 8'h00, 8'hE7, 1'b1};
    tv[16] = '{1'b1, 2'b00, 2'b10, 8'hA5, 8'h5A, 8'h99, 2'b00, 8'h00, 8'h00, 8'hE7, 1'b0};
    tv[17] = '{1'b1, 2'b00, 2'b00, 8'hA5, 8'h5A, 8'h99, 2'b00, 8'h00, 8'h00, 8'hE7, 1'b0};

    bus.req = 2'b00;  bus.wr = 2'b00;  bus.wdata0 = 8'h00; bus.wdata1 = 8'h00; bus.uio_in = 8'h00;
    bus3.req = 2'b00; bus3.wr = 2'b11; bus3.wdata0 = 8'h00; bus3.wdata1 = 8'h5A; bus3.uio_in = 8'h00;

    // Reset state
    repeat (2) tick();
    chk_bus("reset", 2'b00, 8'h00, 8'h00);
    chk("reset rdata", bus.rdata, 8'h00);
    chk("reset rvalid", 8'(bus.rvalid), 8'd0);
    chk("reset dut3 gnt", 8'(bus3.gnt), 8'd0);
    rst = 1'b0;
    ena = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      ena        = tv[i].ena;
      bus.req    = tv[i].req;
      bus.wr     = tv[i].wr;
      bus.wdata0 = tv[i].wd0;
      bus.wdata1 = tv[i].wd1;
      bus.uio_in = tv[i].uin;
      tick();
      chk_bus($sformatf("vec%0d", i), tv[i].gnt, tv[i].oe, tv[i].out);
      chk($sformatf("vec%0d rdata", i), bus.rdata, tv[i].rdata);
      chk($sformatf("vec%0d rvalid", i), 8'(bus.rvalid), 8'(tv[i].rvalid));
    end

    // Both requesting: 16 cycles each owner separated by one turnaround cycle
    bus.req = 2'b11; bus.wr = 2'b11; bus.wdata0 = 8'h11; bus.wdata1 = 8'h22;
    for (int i = 0; i < 50; i++) begin
      tick();
      if ((i % 17) == 16) eg = 2'b00;
      else eg = (((i / 17) % 2) == 0) ? 2'b10 : 2'b01;
      eo = (eg == 2'b10) ? 8'h22 : (eg == 2'b01) ? 8'h11 : 8'h00;
      chk_bus($sformatf("hold%0d", i), eg, (eg != 2'b00) ? 8'hFF : 8'h00, eo);
    end
    bus.req = 2'b00;
    tick();
    tick();
    chk_bus("hold end", 2'b00, 8'h00, 8'h00);

    // Lone requester keeps the bus past MAX_HOLD, then yields once the other asks
    bus.req = 2'b01;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_bus($sformatf("sat%0d", i), 2'b01, 8'hFF, 8'h11);
    end
    bus.req = 2'b11;
    tick();
    chk_bus("forced release", 2'b00, 8'h00, 8'h00);
    tick();
    chk_bus("after forced", 2'b10, 8'hFF, 8'h22);
    bus.req = 2'b00;
    tick();
    tick();

    // TURNAROUND=3: release with the other pending gives three idle cycles
    bus3.req = 2'b01;
    tick();
    chk("t3 grant0", 8'(bus3.gnt), 8'(2'b01));
    chk("t3 oe0", bus3.uio_oe, 8'hFF);
    bus3.req = 2'b10;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t3 turn%0d gnt", k), 8'(bus3.gnt), 8'(2'b00));
      chk($sformatf("t3 turn%0d oe", k), bus3.uio_oe, 8'h00);
    end
    tick();
    chk("t3 grant1", 8'(bus3.gnt), 8'(2'b10));
    chk("t3 out1", bus3.uio_out, 8'h5A);
    inv("t3", bus3.gnt, bus3.uio_oe);
    bus3.req = 2'b00;

    // Asynchronous reset while requester 0 drives the pins
    bus.req = 2'b01; bus.wr = 2'b01; bus.wdata0 = 8'hA5;
    tick();
    chk_bus("pre rst", 2'b01, 8'hFF, 8'hA5);
    rst = 1'b1;
    #1;
    chk_bus("async rst", 2'b00, 8'h00, 8'h00);
    chk("async rst rdata", bus.rdata, 8'h00);
    #1;
    rst = 1'b0;

    // Tie right after a requester-0 grant
    bus.req = 2'b11;
    tick();
    chk_bus("tie first", 2'b01, 8'hFF, 8'hA5);
    bus.req = 2'b00;
    tick();
    tick();
    bus.req = 2'b11;
    tick();
`ifdef UIO_ARB_FIXED_PRIORITY_EN
    chk_bus("tie second", 2'b01, 8'hFF, 8'hA5);
`else
    chk_bus("tie second", 2'b10, 8'h00, 8'h00);
`endif
    bus.req = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uio_bus_arbiter.md
Name: uio_bus_arbiter

Overview:
- Shares the 8-bit bidirectional uio pin bank of tt_um_ashwin_taichip between two internal requesters, e.g. a config loader and a data streamer.
- Owns uio_oe and uio_out. Grants exclusive bus ownership round-robin, enforces a maximum hold time, and inserts bus-turnaround cycles with all pins tri-stated between owners.
- Sits between the top-level uio ports and the core logic.

Parameters:
- TURNAROUND, 1, tri-state cycles (uio_oe=0) inserted between consecutive grants; legal range 1..7.
- MAX_HOLD, 16, maximum consecutive GRANT cycles while the other requester is pending; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  design enable; low forces the bus idle.
- req  input  2  request per requester (bit0 = requester 0); level, held until done.
- wr  input  2  per-requester direction (1 = drive pins, 0 = read pins); latched at grant.
- wdata0  input  8  write data, requester 0.
- wdata1  input  8  write data, requester 1.
- gnt  output  2  one-hot-or-zero grant, registered.
- uio_in  input  8  pin input path.
- uio_out  output  8  pin output path.
- uio_oe  output  8  pin output enable, registered, all-or-nothing.
- rdata  output  8  registered sample of uio_in for the reading owner.
- rvalid  output  1  rdata updated this cycle.

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, uio_oe=0, uio_out=0, rdata=0, rvalid=0, rr pointer=1 (requester 0 wins the first tie), hold and turnaround counters=0.
- States: IDLE, GRANT, TURN.
- IDLE: pins tri-stated. If ena and |req, pick winner at the edge and enter GRANT. gnt[w]=1 and uio_oe=wr[w]?8'hFF:8'h00 are visible the cycle after req is first seen (latency 1). No turnaround is needed from IDLE.
- Winner selection: round-robin. If both requesters ask, pick the one not granted last, then update the pointer to the winner. A single requester wins regardless of the pointer.
- GRANT:
  - uio_out = latched-wr owner's wdata, muxed combinationally from the registered grant; uio_out=0 when not driving.
  - Reading owner: rdata<=uio_in every cycle and rvalid=1 the following cycle.
  - A wr change during a grant is ignored.
- Release: an edge sampling req[owner]=0 moves to TURN. gnt and uio_oe clear at that edge.
- Forced release: hold counter increments each GRANT cycle. When it reaches MAX_HOLD-1 and the other req is high, the next edge moves to TURN even though req[owner] is still high. If the other req is low, the counter saturates and the grant continues.
- TURN: gnt=0, uio_oe=0, rvalid=0 for exactly TURNAROUND cycles, then IDLE-equivalent selection at the exit edge. The next grant is visible TURNAROUND+1 cycles after release. Requests arriving during TURN are not dropped.
- ena=0 in any state: next edge enters IDLE with gnt=0 and uio_oe=0. The rr pointer is kept.
- Simultaneous release and new request: the turnaround is still inserted, with no back-to-back grants.
- Asynchronous reset mid-grant tri-states the pins immediately.
- Invariants:
  - $onehot0(gnt).
  - uio_oe is 0 whenever gnt==0.
  - uio_oe is only 8'h00 or 8'hFF.

Optional Feature:
- Macro: UIO_ARB_FIXED_PRIORITY_EN.
- Defined: requester 0 always wins ties and the rr pointer is unused. Forced release via MAX_HOLD still applies, so requester 1 cannot starve.
- Undefined: round-robin as above.

Decomposition:
- Package uio_arb_pkg holds:
  - state enum (IDLE, GRANT, TURN);
  - OE_NONE=8'h00 and OE_ALL=8'hFF;
  - requester index constants REQ0=0 and REQ1=1.
- One sub-module, uio_rr_pick: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last[0:0], fixed-priority select.
  - Outputs: win_valid, win_idx.

Test Plan:
- Reset then req=2'b01, wr=2'b01, wdata0=8'hA5 -> next cycle gnt=01, uio_oe=FF, uio_out=A5; drop req -> next edge gnt=00, uio_oe=00.
- req=2'b10, wr=00, uio_in=8'h3C -> gnt=10, uio_oe=00, rdata=3C with rvalid=1 one cycle after grant.
- Both req high continuously, MAX_HOLD=16, TURNAROUND=1 -> grants alternate 01 (16 cycles), 1 idle cycle, 10 (16 cycles), repeating.
- Owner 0 releases while req1 high, TURNAROUND=3 -> exactly 3 cycles of gnt=00/uio_oe=00, then gnt=10.
- Owner 0 writing, assert rst mid-grant -> uio_oe=00 and gnt=00 immediately, before the next clock edge.
- UIO_ARB_FIXED_PRIORITY_EN defined, both req rising together after a requester-0 grant -> requester 0 wins again; round-robin build -> requester 1 wins.
